dilithium_job_arbiter: RTL and testbench
========================================

Name: dilithium_job_arbiter

Overview:
- Shares one dilithium_high_perf core between two independent requesters (req0, req1).
- Arbitrates job ownership round-robin and latches the winning requester's mode/sec_lvl.
- Issues the core start pulse, then routes both 64-bit streams to the owner until the core signals done.
- A stall watchdog aborts hung jobs by pulsing a core reset.

Parameters:
- TIMEOUT_CYCLES, 65536: consecutive cycles with no stream handshake in RUN before abort.
- ABORT_RST_CYCLES, 4: length of the core_rst pulse during abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reqN_req  in  1  (N=0,1) job request; level, held until gntN or reqN_err
- reqN_mode  in  2  job mode; 0 keygen, 1 verify, 2 sign, 3 illegal
- reqN_sec_lvl  in  3  security level; legal values 2, 3, 5
- gntN  out  1  requester N owns the core
- reqN_err  out  1  one-cycle pulse: request rejected or job aborted
- reqN_valid_i / reqN_ready_i / reqN_data_i  in/out/in  1/1/64  input stream from requester N
- reqN_valid_o / reqN_ready_o / reqN_data_o  out/in/out  1/1/64  output stream to requester N
- reqN_done / reqN_last  out  1/1  core done/last, forwarded to the owner only
- core_start  out  1  start pulse to core
- core_mode / core_sec_lvl  out  2/3  latched job configuration
- core_rst  out  1  core reset = rst OR abort pulse
- core_valid_i / core_ready_i / core_data_i  out/in/out  1/1/64  core input stream
- core_valid_o / core_ready_o / core_data_o  in/out/in  1/1/64  core output stream
- core_done / core_last  in  1/1  from core
- busy  out  1  high in every state other than IDLE

Behaviour:
- States: IDLE, ISSUE, RUN, RELEASE, ABORT.
- Reset:
  - State IDLE, RR pointer = 0 (req0 favoured), owner = 0.
  - Watchdog and abort counters cleared; latched mode/sec_lvl cleared to 0.
  - All outputs 0, except core_rst = 1 while rst is high.
- IDLE:
  - Candidate = requester with req high. If both are high, take the RR pointer's requester.
  - If the candidate's mode = 3 or sec_lvl is not in {2,3,5}:
    - Pulse that requester's reqN_err for 1 cycle and stay IDLE.
    - The RR pointer moves to the other requester, so an illegal requester cannot starve the other.
  - Otherwise:
    - Latch owner, mode, sec_lvl.
    - Assert gnt(owner) from the next cycle.
    - Go to ISSUE.
- ISSUE:
  - core_start = 1 for exactly this cycle; core_mode/core_sec_lvl hold the latched values.
  - Go to RUN.
- RUN: streams are combinational muxes.
  - core_valid_i = owner valid_i; core_data_i = owner data_i; owner ready_i = core_ready_i.
  - owner valid_o = core_valid_o; owner data_o = core_data_o; core_ready_o = owner ready_o.
  - owner done/last = core_done/core_last.
  - Non-owner ready_i, valid_o, done and last are 0.
  - Outside RUN: core_valid_i = 0, core_ready_o = 0, all requester stream outputs = 0.
- RUN exits:
  - core_done = 1 goes to RELEASE. The same-cycle output handshake completes normally.
  - Watchdog resets on any handshake (valid&ready on either core stream) and otherwise increments.
  - Watchdog reaching TIMEOUT_CYCLES-1 with no handshake goes to ABORT. core_done takes priority if both occur in the same cycle.
- RELEASE:
  - gnt deasserts. The RR pointer is set to the non-owner.
  - Go to IDLE. A new grant can appear at the earliest 2 cycles after RELEASE.
- ABORT:
  - core_rst = 1 for ABORT_RST_CYCLES cycles; gnt deasserted.
  - Owner reqN_err pulses on the first ABORT cycle.
  - RR pointer moves to the non-owner; return to IDLE.
- The owner dropping reqN_req mid-job has no effect; jobs end only on done or abort.
- Latched mode/sec_lvl are stable from ISSUE through RELEASE/ABORT. Requester mode/sec_lvl changes after the grant are ignored.
- rst mid-job: next cycle is IDLE with all state cleared; no err pulse.

Test Plan:
- req0 only, mode=2, sec_lvl=3 -> gnt0 next cycle; core_start high exactly 1 cycle; core_mode=2, core_sec_lvl=3; req0 streams pass through; core_done -> gnt0 low, busy low 1 cycle later.
- req0 and req1 high together after reset -> req0 served first; req1 granted 2 cycles after req0 RELEASE; next simultaneous request goes to req0 again.
- req1 with mode=3, then req1 with sec_lvl=4 -> req1_err 1-cycle pulse each time; no core_start; gnt1 never asserted.
- TIMEOUT_CYCLES=16: grant, then hold req0_valid_i=0 and req0_ready_o=0 -> ABORT 16 cycles after entering RUN; core_rst high 4 cycles; req0_err pulse; IDLE afterwards.
- During a req0 job, hold req1_valid_i=1 with data 0xDEAD -> core_data_i never equals req1 data; req1_ready_i stays 0 throughout.
- Assert rst for 1 cycle mid-RUN -> all outputs 0 the next cycle; core_rst high during rst; no err pulse.

Source files
------------

// File: rtl/dilithium_job_arbiter.sv
// Shares one dilithium core between two requesters: round-robin grant, start pulse, stream routing, stall watchdog.
// Latency: grant one cycle after an accepted request, core_start on the grant cycle, streams are combinational in RUN.
// Backpressure: ready/valid passed straight through to the owner; non-owner sees ready=0 and valid=0.
module dilithium_job_arbiter #(
  parameter int TIMEOUT_CYCLES   = 65536,
  parameter int ABORT_RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_req,
  input  logic [1:0]  req0_mode,
  input  logic [2:0]  req0_sec_lvl,
  output logic        gnt0,
  output logic        req0_err,
  input  logic        req0_valid_i,
  output logic        req0_ready_i,
  input  logic [63:0] req0_data_i,
  output logic        req0_valid_o,
  input  logic        req0_ready_o,
  output logic [63:0] req0_data_o,
  output logic        req0_done,
  output logic        req0_last,
  input  logic        req1_req,
  input  logic [1:0]  req1_mode,
  input  logic [2:0]  req1_sec_lvl,
  output logic        gnt1,
  output logic        req1_err,
  input  logic        req1_valid_i,
  output logic        req1_ready_i,
  input  logic [63:0] req1_data_i,
  output logic        req1_valid_o,
  input  logic        req1_ready_o,
  output logic [63:0] req1_data_o,
  output logic        req1_done,
  output logic        req1_last,
  output logic        core_start,
  output logic [1:0]  core_mode,
  output logic [2:0]  core_sec_lvl,
  output logic        core_rst,
  output logic        core_valid_i,
  input  logic        core_ready_i,
  output logic [63:0] core_data_i,
  input  logic        core_valid_o,
  output logic        core_ready_o,
  input  logic [63:0] core_data_o,
  input  logic        core_done,
  input  logic        core_last,
  output logic        busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AB_W = $clog2(ABORT_RST_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AB_W-1:0] AB_LAST = AB_W'(ABORT_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RUN, S_RELEASE, S_ABORT
  } state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            owner_q, owner_d;
  logic [1:0]      mode_q, mode_d;
  logic [2:0]      sec_q, sec_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [AB_W-1:0] ab_q, ab_d;

  logic       run;
  logic       cand;
  logic [1:0] cand_mode;
  logic [2:0] cand_sec;
  logic       cand_legal;
  logic       reject;
  logic       hs;
  logic       abort_first;
  logic       own0;
  logic       own1;

  assign run  = (state_q == S_RUN);
  assign own0 = run && !owner_q;
  assign own1 = run &&  owner_q;

  // Pick the candidate requester (RR pointer breaks ties) and check its job configuration.
  always_comb begin
    cand = rr_q;
    if (req0_req && !req1_req) cand = 1'b0;
    else if (req1_req && !req0_req) cand = 1'b1;
    cand_mode  = cand ? req1_mode    : req0_mode;
    cand_sec   = cand ? req1_sec_lvl : req0_sec_lvl;
    cand_legal = (cand_mode != 2'd3) &&
                 ((cand_sec == 3'd2) || (cand_sec == 3'd3) || (cand_sec == 3'd5));
  end

  // Stream routing: only the owner is connected, and only while the job runs.
  assign core_valid_i = run && (owner_q ? req1_valid_i : req0_valid_i);
  assign core_data_i  = run ? (owner_q ? req1_data_i : req0_data_i) : 64'd0;
  assign core_ready_o = run && (owner_q ? req1_ready_o : req0_ready_o);
  assign req0_ready_i = own0 && core_ready_i;
  assign req1_ready_i = own1 && core_ready_i;
  assign req0_valid_o = own0 && core_valid_o;
  assign req1_valid_o = own1 && core_valid_o;
  assign req0_data_o  = own0 ? core_data_o : 64'd0;
  assign req1_data_o  = own1 ? core_data_o : 64'd0;
  assign req0_done    = own0 && core_done;
  assign req1_done    = own1 && core_done;
  assign req0_last    = own0 && core_last;
  assign req1_last    = own1 && core_last;

  assign hs = (core_valid_i && core_ready_i) || (core_valid_o && core_ready_o);

  assign gnt0         = ((state_q == S_ISSUE) || run) && !owner_q;
  assign gnt1         = ((state_q == S_ISSUE) || run) &&  owner_q;
  assign busy         = (state_q != S_IDLE);
  assign core_rst     = rst || (state_q == S_ABORT);
  assign core_mode    = mode_q;
  assign core_sec_lvl = sec_q;

  // Error pulses are suppressed while rst is high so a reset never looks like a rejection.
  assign abort_first = (state_q == S_ABORT) && (ab_q == '0);
  assign req0_err = !rst && ((reject && !cand) || (abort_first && !owner_q));
  assign req1_err = !rst && ((reject &&  cand) || (abort_first &&  owner_q));

  // Next-state logic: arbitration, job sequencing, watchdog and abort timing.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    mode_d     = mode_q;
    sec_d      = sec_q;
    wd_d       = '0;
    ab_d       = '0;
    reject     = 1'b0;
    core_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_req || req1_req) begin
          if (!cand_legal) begin
            // Move the pointer away so a misbehaving requester cannot starve the other.
            reject = 1'b1;
            rr_d   = ~cand;
          end else begin
            owner_d = cand;
            mode_d  = cand_mode;
            sec_d   = cand_sec;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        core_start = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (core_done) begin
          state_d = S_RELEASE;
        end else if (!hs && (wd_q == WD_LAST)) begin
          state_d = S_ABORT;
        end else begin
          wd_d = hs ? '0 : wd_q + 1'b1;
        end
      end
      S_RELEASE: begin
        rr_d    = ~owner_q;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        if (ab_q == AB_LAST) begin
          rr_d    = ~owner_q;
          state_d = S_IDLE;
        end else begin
          ab_d = ab_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      mode_q  <= 2'd0;
      sec_q   <= 3'd0;
      wd_q    <= '0;
      ab_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      mode_q  <= mode_d;
      sec_q   <= sec_d;
      wd_q    <= wd_d;
      ab_q    <= ab_d;
    end
  end

endmodule

// File: tb/tb_dilithium_job_arbiter.sv
// Directed bench for dilithium_job_arbiter with a short watchdog (16 cycles).
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
// Expected values are hand-derived constants.
module tb_dilithium_job_arbiter;

  logic        clk, rst;
  logic        req0_req, req1_req;
  logic [1:0]  req0_mode, req1_mode;
  logic [2:0]  req0_sec_lvl, req1_sec_lvl;
  logic        gnt0, gnt1, req0_err, req1_err;
  logic        req0_valid_i, req1_valid_i, req0_ready_i, req1_ready_i;
  logic [63:0] req0_data_i, req1_data_i, req0_data_o, req1_data_o;
  logic        req0_valid_o, req1_valid_o, req0_ready_o, req1_ready_o;
  logic        req0_done, req1_done, req0_last, req1_last;
  logic        core_start, core_rst, busy;
  logic [1:0]  core_mode;
  logic [2:0]  core_sec_lvl;
  logic        core_valid_i, core_ready_i, core_valid_o, core_ready_o;
  logic [63:0] core_data_i, core_data_o;
  logic        core_done, core_last;

  int n_tests = 0;
  int n_fail  = 0;

  dilithium_job_arbiter #(.TIMEOUT_CYCLES(16), .ABORT_RST_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_req(req0_req), .req0_mode(req0_mode), .req0_sec_lvl(req0_sec_lvl),
    .gnt0(gnt0), .req0_err(req0_err),
    .req0_valid_i(req0_valid_i), .req0_ready_i(req0_ready_i), .req0_data_i(req0_data_i),
    .req0_valid_o(req0_valid_o), .req0_ready_o(req0_ready_o), .req0_data_o(req0_data_o),
    .req0_done(req0_done), .req0_last(req0_last),
    .req1_req(req1_req), .req1_mode(req1_mode), .req1_sec_lvl(req1_sec_lvl),
    .gnt1(gnt1), .req1_err(req1_err),
    .req1_valid_i(req1_valid_i), .req1_ready_i(req1_ready_i), .req1_data_i(req1_data_i),
    .req1_valid_o(req1_valid_o), .req1_ready_o(req1_ready_o), .req1_data_o(req1_data_o),
    .req1_done(req1_done), .req1_last(req1_last),
    .core_start(core_start), .core_mode(core_mode), .core_sec_lvl(core_sec_lvl),
    .core_rst(core_rst),
    .core_valid_i(core_valid_i), .core_ready_i(core_ready_i), .core_data_i(core_data_i),
    .core_valid_o(core_valid_o), .core_ready_o(core_ready_o), .core_data_o(core_data_o),
    .core_done(core_done), .core_last(core_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    req0_req = 0; req0_mode = 0; req0_sec_lvl = 0;
    req1_req = 0; req1_mode = 0; req1_sec_lvl = 0;
    req0_valid_i = 0; req0_data_i = 0; req0_ready_o = 0;
    req1_valid_i = 0; req1_data_i = 0; req1_ready_o = 0;
    core_ready_i = 0; core_valid_o = 0; core_data_o = 0;
    core_done = 0; core_last = 0;

    // ---- reset ----
    step(); step();
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gnt0", gnt0, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_core_rst", core_rst, 0);
    chk("post_rst_mode", core_mode, 0);
    chk("post_rst_sec", core_sec_lvl, 0);

    // ---- single job on req0: mode 2, sec 3 ----
    req0_req = 1; req0_mode = 2; req0_sec_lvl = 3;
    #1;
    chk("t1_idle_gnt0", gnt0, 0);
    chk("t1_idle_err0", req0_err, 0);
    step();                                   // ISSUE
    req0_req = 0; req0_mode = 0;              // later config changes must be ignored
    #1;
    chk("t1_gnt0", gnt0, 1);
    chk("t1_start", core_start, 1);
    chk("t1_mode", core_mode, 2);
    chk("t1_sec", core_sec_lvl, 3);
    chk("t1_busy", busy, 1);
    step();                                   // RUN
    req0_valid_i = 1; req0_data_i = 64'h1234_5678_9ABC_DEF0; core_ready_i = 1;
    core_valid_o = 1; core_data_o = 64'hCAFE_F00D_0000_0001; req0_ready_o = 1;
    #1;
    chk("t1_start_once", core_start, 0);
    chk("t1_mode_held", core_mode, 2);
    chk("t1_core_valid_i", core_valid_i, 1);
    chk("t1_core_data_i", core_data_i, 64'h1234_5678_9ABC_DEF0);
    chk("t1_req0_ready_i", req0_ready_i, 1);
    chk("t1_req0_valid_o", req0_valid_o, 1);
    chk("t1_req0_data_o", req0_data_o, 64'hCAFE_F00D_0000_0001);
    chk("t1_core_ready_o", core_ready_o, 1);
    chk("t1_req1_valid_o", req1_valid_o, 0);
    core_done = 1; core_last = 1;
    #1;
    chk("t1_req0_done", req0_done, 1);
    chk("t1_req0_last", req0_last, 1);
    chk("t1_req1_done", req1_done, 0);
    step();                                   // RELEASE
    req0_valid_i = 0; req0_data_i = 0; core_ready_i = 0;
    core_valid_o = 0; core_data_o = 0; req0_ready_o = 0;
    core_done = 0; core_last = 0;
    #1;
    chk("t1_rel_gnt0", gnt0, 0);
    chk("t1_rel_busy", busy, 1);
    step();                                   // IDLE
    #1;
    chk("t1_idle_busy", busy, 0);

    // ---- simultaneous requests after reset, plus non-owner isolation ----
    rst = 1;
    step();
    rst = 0;
    req0_req = 1; req0_mode = 0; req0_sec_lvl = 2;
    req1_req = 1; req1_mode = 1; req1_sec_lvl = 5;
    step();                                   // ISSUE for req0
    req0_req = 0;
    #1;
    chk("t2_gnt0_first", gnt0, 1);
    chk("t2_gnt1_wait", gnt1, 0);
    chk("t2_mode0", core_mode, 0);
    step();                                   // RUN (req0)
    req1_valid_i = 1; req1_data_i = 64'hDEAD; core_ready_i = 1;
    #1;
    chk("t5_core_valid_i", core_valid_i, 0);
    chk("t5_core_data_i", core_data_i, 0);
    chk("t5_req1_ready_i", req1_ready_i, 0);
    step();                                   // RUN, second cycle
    core_done = 1;
    #1;
    chk("t5_core_data_i_2", core_data_i, 0);
    chk("t5_req1_ready_i_2", req1_ready_i, 0);
    chk("t2_req0_done", req0_done, 1);
    chk("t2_req1_done", req1_done, 0);
    step();                                   // RELEASE
    core_done = 0; req1_valid_i = 0; req1_data_i = 0; core_ready_i = 0;
    #1;
    chk("t2_rel_gnt0", gnt0, 0);
    chk("t2_rel_gnt1", gnt1, 0);
    step();                                   // IDLE, picks req1
    #1;
    chk("t2_rel1_gnt1", gnt1, 0);
    step();                                   // ISSUE for req1
    req1_req = 0;
    #1;
    chk("t2_gnt1", gnt1, 1);
    chk("t2_mode1", core_mode, 1);
    chk("t2_sec1", core_sec_lvl, 5);
    step();                                   // RUN (req1)
    core_done = 1;
    #1;
    chk("t2_req1_done_run", req1_done, 1);
    chk("t2_req0_done_run", req0_done, 0);
    step();                                   // RELEASE, pointer back to req0
    core_done = 0;
    req0_req = 1; req1_req = 1;
    step();                                   // IDLE
    step();                                   // ISSUE
    req0_req = 0; req1_req = 0;
    #1;
    chk("t2_rr_gnt0", gnt0, 1);
    chk("t2_rr_gnt1", gnt1, 0);
    step();                                   // RUN
    core_done = 1;
    step();                                   // RELEASE
    core_done = 0;
    step();                                   // IDLE

    // ---- illegal requests on req1 ----
    req1_req = 1; req1_mode = 3; req1_sec_lvl = 3;
    #1;
    chk("t3_err_mode", req1_err, 1);
    chk("t3_err0_quiet", req0_err, 0);
    step();
    req1_req = 0;
    #1;
    chk("t3_err_pulse_end", req1_err, 0);
    chk("t3_no_gnt1", gnt1, 0);
    chk("t3_no_start", core_start, 0);
    chk("t3_not_busy", busy, 0);
    req1_req = 1; req1_mode = 0; req1_sec_lvl = 4;
    #1;
    chk("t3_err_sec", req1_err, 1);
    step();
    req1_req = 0;
    #1;
    chk("t3_no_gnt1_b", gnt1, 0);
    chk("t3_not_busy_b", busy, 0);

    // ---- watchdog abort ----
    req0_req = 1; req0_mode = 1; req0_sec_lvl = 2;
    step();                                   // ISSUE
    req0_req = 0;
    step();                                   // RUN entry
    repeat (15) step();                       // 15 cycles into RUN, still running
    #1;
    chk("t4_still_run_rst", core_rst, 0);
    chk("t4_still_gnt0", gnt0, 1);
    step();                                   // ABORT, first cycle
    #1;
    chk("t4_abort_rst", core_rst, 1);
    chk("t4_abort_err0", req0_err, 1);
    chk("t4_abort_gnt0", gnt0, 0);
    chk("t4_abort_busy", busy, 1);
    step();
    #1;
    chk("t4_abort_rst2", core_rst, 1);
    chk("t4_abort_err_end", req0_err, 0);
    step();
    #1;
    chk("t4_abort_rst3", core_rst, 1);
    step();
    #1;
    chk("t4_abort_rst4", core_rst, 1);
    step();                                   // IDLE
    #1;
    chk("t4_after_rst", core_rst, 0);
    chk("t4_after_busy", busy, 0);

    // ---- reset in the middle of a job ----
    req0_req = 1; req0_mode = 2; req0_sec_lvl = 5;
    step();                                   // ISSUE
    req0_req = 0;
    step();                                   // RUN
    core_valid_o = 1; core_data_o = 64'h55; req0_ready_o = 1;
    #1;
    chk("t6_run_valid_o", req0_valid_o, 1);
    rst = 1;
    #1;
    chk("t6_rst_core_rst", core_rst, 1);
    chk("t6_rst_no_err", req0_err, 0);
    step();                                   // IDLE after reset
    rst = 0;
    #1;
    chk("t6_gnt0", gnt0, 0);
    chk("t6_busy", busy, 0);
    chk("t6_valid_o", req0_valid_o, 0);
    chk("t6_core_ready_o", core_ready_o, 0);
    chk("t6_core_rst", core_rst, 0);
    chk("t6_mode", core_mode, 0);
    chk("t6_err", req0_err, 0);
    core_valid_o = 0; core_data_o = 0; req0_ready_o = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
